gcbp_banked: RTL
================

Name: gcbp_banked

Overview:
Parametrised successor to the gray-coded bit-plane (GCBP) extractor in the stabilisation front end. It takes a luma pixel stream, forms one runtime-selectable gray-coded bit plane, and packs BANK_W plane bits per word. Words are distributed round-robin across BANKS BRAM banks, into a rotating set of NUM_FRAMES frame buffers. It feeds the motion-estimation BRAM array and publishes next/curr/prev buffer locations to the matcher.

Parameters:
LUMA_W, 8, luma sample width.
BANK_W, 8, plane bits per bank word (pixels per word).
BANKS, 16, number of BRAM banks; write data is BANKS*BANK_W wide.
PIX_PER_LINE, 640, active pixels per line; must be a multiple of BANK_W.
LINES, 480, active lines per frame.
NUM_FRAMES, 3, frame buffers rotated; must be >= 3.
Derived localparams:
- WPL = ceil(PIX_PER_LINE/(BANK_W*BANKS)), words per line per bank.
- FRAME_WORDS = LINES*WPL.
- ADDR_W = clog2(NUM_FRAMES*FRAME_WORDS).
- LOC_W = clog2(NUM_FRAMES).
- SEL_W = clog2(LUMA_W).

Ports:
i_clk  in  1  sole clock.
i_reset  in  1  asynchronous, active-high reset.
i_luma_data  in  LUMA_W  pixel sample.
i_luma_data_valid  in  1  sample qualifier.
i_new_line  in  1  one-cycle pulse at line start.
i_line_cnt  in  clog2(LINES)+1  line index of the current line.
i_new_frame  in  1  one-cycle pulse at frame start.
i_plane_sel  in  SEL_W  bit plane k; sampled only on i_new_frame.
o_bram_array_write_addr  out  ADDR_W  word address within the bank.
o_bram_array_write_data  out  BANKS*BANK_W  packed word, replicated into every bank lane.
o_bram_array_write_enable  out  BANKS  one-hot bank strobe.
o_next_frame_loc  out  LOC_W  buffer currently being written.
o_curr_frame_loc  out  LOC_W  most recently completed buffer.
o_prev_frame_loc  out  LOC_W  buffer completed before curr.
o_frame_done  out  1  one-cycle pulse on each rotation.
o_overflow  out  1  sticky flag: pixel or line dropped; cleared only by reset.

Behaviour:
- Reset values:
  - all write outputs 0; o_frame_done 0; o_overflow 0.
  - next_loc 0; curr_loc NUM_FRAMES-1; prev_loc NUM_FRAMES-2.
  - plane_sel register 0; FSM in S_WAIT_FRAME.
- Reset asserted mid-line discards any partial word; nothing is written.
- FSM S_WAIT_FRAME:
  - ignores valid and new_line.
  - on i_new_frame: latch i_plane_sel, clear counters, go to S_RUN. No rotation, no o_frame_done.
- FSM S_RUN, on i_new_frame:
  - flush any partial word.
  - rotate: prev<=curr, curr<=next, next<=(next+1) mod NUM_FRAMES.
  - pulse o_frame_done, relatch plane_sel, clear pixel/column counters.
- Gray plane bit:
  - g = luma[k] ^ luma[k+1] for k < LUMA_W-1.
  - g = luma[LUMA_W-1] for k = LUMA_W-1.
  - plane_sel values >= LUMA_W are treated as LUMA_W-1.
- Packing:
  - each valid pixel shifts g into the accumulator, first pixel at the LSB.
  - after BANK_W pixels, the word is written on the next cycle. Latency is 1 cycle from the last contributing valid.
- Addressing, for column c = pixel_cnt/BANK_W:
  - bank = c mod BANKS.
  - addr = next_loc*FRAME_WORDS + i_line_cnt*WPL + c/BANKS.
  - the address uses next_loc as it stood when the word completed.
- i_new_line with a partial word: write the word zero-padded in the upper bits, then reset the pixel counter.
- Same cycle as new_line:
  - i_luma_data_valid: the flush happens first; the pixel is pixel 0 of the new line.
  - i_new_frame: treated as new_frame only.
- Drops, each setting o_overflow:
  - pixels with pixel_cnt >= PIX_PER_LINE.
  - any pixel with i_line_cnt >= LINES.
- Write enable is high for exactly one cycle per word; no back-pressure.

Optional Feature:
GCBP_FRAME_STATS_EN:
- When defined: adds output o_plane_ones [clog2(LINES*PIX_PER_LINE+1)-1:0], a count of plane bits equal to 1 over the frame. It is latched at rotation, is valid from the o_frame_done cycle, and resets to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package gcbp_pkg: the derived localparams and a clog2 function, plus FSM state encoding S_WAIT_FRAME/S_RUN and the loc_t width.
- One sub-module, gcbp_frame_rotator: holds the next/curr/prev registers, the rotate strobe and o_frame_done.

Test Plan:
1. Reset, then valid pixels with no new_frame -> no write enable ever, o_overflow 0.
2. new_frame with plane_sel=4, then 8 valid pixels 0x10 (bit4=1, bit5=0) -> one cycle later enable=16'h0001, data lane0=8'hFF, addr=0.
3. Full line of 640 pixels at line_cnt=1 -> 80 writes; banks cycle 0..15 five times; addr 5..9; bank 15 receives its last write at addr 9.
4. 3 pixels then new_line -> flush data 8'b00000111 (g=1); pixel on the same cycle as new_line lands at bit0 of the next word.
5. Three new_frame pulses after the first -> locs (next,curr,prev) go (1,0,2), (2,1,0), (0,2,1); o_frame_done pulses 3 times; addr base 2400 during next=1.
6. 641st pixel, or line_cnt=480 -> no write, o_overflow=1 held; assert i_reset mid-line -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/gcbp_pkg.sv
// gcbp_pkg: shared constants, width helper and FSM encoding for the banked
// gray-coded bit-plane extractor. Default derived sizes match the default
// parameter set of gcbp_banked; the module recomputes them for its own
// parameter values.
package gcbp_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Words per line per bank: ceil(pixels / (pixels per word * banks)).
  function automatic int calc_wpl(input int ppl, input int bank_w, input int banks);
    return (ppl + bank_w * banks - 1) / (bank_w * banks);
  endfunction

  localparam int LUMA_W_DEF       = 8;
  localparam int BANK_W_DEF       = 8;
  localparam int BANKS_DEF        = 16;
  localparam int PIX_PER_LINE_DEF = 640;
  localparam int LINES_DEF        = 480;
  localparam int NUM_FRAMES_DEF   = 3;

  localparam int WPL_DEF         = calc_wpl(PIX_PER_LINE_DEF, BANK_W_DEF, BANKS_DEF);
  localparam int FRAME_WORDS_DEF = LINES_DEF * WPL_DEF;
  localparam int ADDR_W_DEF      = clog2(NUM_FRAMES_DEF * FRAME_WORDS_DEF);
  localparam int LOC_W_DEF       = clog2(NUM_FRAMES_DEF);
  localparam int SEL_W_DEF       = clog2(LUMA_W_DEF);

  // Top-level control FSM encoding.
  typedef enum logic [0:0] {
    S_WAIT_FRAME = 1'b0,
    S_RUN        = 1'b1
  } state_t;

  // Frame buffer location for the default build.
  typedef logic [LOC_W_DEF-1:0] loc_t;

endpackage

// File: rtl/gcbp_frame_rotator.sv
// gcbp_frame_rotator: keeps the next/curr/prev frame buffer locations and
// rotates them on each strobe; o_frame_done is a registered copy of the
// strobe so it lines up with the updated locations.
module gcbp_frame_rotator
  import gcbp_pkg::*;
#(
  parameter int NUM_FRAMES = NUM_FRAMES_DEF,
  parameter int LOC_W      = clog2(NUM_FRAMES)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_rotate,
  output logic [LOC_W-1:0] o_next_loc,
  output logic [LOC_W-1:0] o_curr_loc,
  output logic [LOC_W-1:0] o_prev_loc,
  output logic             o_frame_done
);

  logic [LOC_W-1:0] r_next;
  logic [LOC_W-1:0] r_curr;
  logic [LOC_W-1:0] r_prev;
  logic             r_done;
  logic [LOC_W-1:0] w_next_inc;

  // Modulo-NUM_FRAMES increment of the write buffer location.
  always_comb begin
    w_next_inc = (r_next == LOC_W'(NUM_FRAMES - 1)) ? '0 : r_next + LOC_W'(1);
  end

  // Rotate prev <= curr <= next <= next+1 and pulse done for one cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_next <= '0;
      r_curr <= LOC_W'(NUM_FRAMES - 1);
      r_prev <= LOC_W'(NUM_FRAMES - 2);
      r_done <= 1'b0;
    end else begin
      r_done <= i_rotate;
      if (i_rotate) begin
        r_prev <= r_curr;
        r_curr <= r_next;
        r_next <= w_next_inc;
      end
    end
  end

  assign o_next_loc   = r_next;
  assign o_curr_loc   = r_curr;
  assign o_prev_loc   = r_prev;
  assign o_frame_done = r_done;

endmodule

// File: rtl/gcbp_banked.sv
// gcbp_banked: forms one gray-coded bit plane from a luma stream, packs
// BANK_W plane bits per word (first pixel at the LSB) and writes the words
// round-robin across BANKS BRAM banks inside a rotating set of frame buffers.
// Optional build macro GCBP_FRAME_STATS_EN adds o_plane_ones, the number of
// plane bits equal to 1 in the frame just completed.
//
// Interface timing: there is no handshake. Each accepted pixel is qualified by
// i_luma_data_valid for exactly one cycle; each word is presented with a
// one-cycle, one-hot o_bram_array_write_enable and must be taken that cycle.
module gcbp_banked
  import gcbp_pkg::*;
#(
  parameter int LUMA_W       = LUMA_W_DEF,
  parameter int BANK_W       = BANK_W_DEF,
  parameter int BANKS        = BANKS_DEF,
  parameter int PIX_PER_LINE = PIX_PER_LINE_DEF,
  parameter int LINES        = LINES_DEF,
  parameter int NUM_FRAMES   = NUM_FRAMES_DEF,
  localparam int WPL         = calc_wpl(PIX_PER_LINE, BANK_W, BANKS),
  localparam int FRAME_WORDS = LINES * WPL,
  localparam int ADDR_W      = clog2(NUM_FRAMES * FRAME_WORDS),
  localparam int LOC_W       = clog2(NUM_FRAMES),
  localparam int SEL_W       = clog2(LUMA_W),
  localparam int LC_W        = clog2(LINES) + 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [LUMA_W-1:0]       i_luma_data,
  input  logic                    i_luma_data_valid,
  input  logic                    i_new_line,
  input  logic [LC_W-1:0]         i_line_cnt,
  input  logic                    i_new_frame,
  input  logic [SEL_W-1:0]        i_plane_sel,
  output logic [ADDR_W-1:0]       o_bram_array_write_addr,
  output logic [BANKS*BANK_W-1:0] o_bram_array_write_data,
  output logic [BANKS-1:0]        o_bram_array_write_enable,
  output logic [LOC_W-1:0]        o_next_frame_loc,
  output logic [LOC_W-1:0]        o_curr_frame_loc,
  output logic [LOC_W-1:0]        o_prev_frame_loc,
  output logic                    o_frame_done,
  output logic                    o_overflow
`ifdef GCBP_FRAME_STATS_EN
  ,
  output logic [clog2(LINES*PIX_PER_LINE+1)-1:0] o_plane_ones
`endif
);

  localparam int PIX_W  = clog2(PIX_PER_LINE + 1);
  localparam int FILL_W = clog2(BANK_W + 1);
  localparam int BSEL_W = (BANKS > 1) ? clog2(BANKS) : 1;
  localparam int WOFS_W = clog2(WPL + 1);
  localparam int KX_W   = clog2(LUMA_W + 1);

  // ---------------------------------------------------------------- FSM
  state_t r_state;
  state_t w_state_nxt;
  logic   w_start;   // new_frame seen in any state: latch plane, clear counters
  logic   w_rotate;  // new_frame while running: flush and rotate buffers
  logic   w_px;      // candidate pixel (running, not a frame-start cycle)
  logic   w_line;    // line start while running (new_frame takes priority)

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_WAIT_FRAME;
    else         r_state <= w_state_nxt;
  end

  // Next-state: leave S_WAIT_FRAME on the first frame pulse, then stay running.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_FRAME: if (i_new_frame) w_state_nxt = S_RUN;
      S_RUN:        w_state_nxt = S_RUN;
      default:      w_state_nxt = S_WAIT_FRAME;
    endcase
  end

  // FSM outputs: decode the control events for the datapath.
  always_comb begin
    w_start  = 1'b0;
    w_rotate = 1'b0;
    w_px     = 1'b0;
    w_line   = 1'b0;
    case (r_state)
      S_WAIT_FRAME: begin
        w_start = i_new_frame;
      end
      S_RUN: begin
        w_start  = i_new_frame;
        w_rotate = i_new_frame;
        // Samples coincident with a frame pulse are not accepted.
        w_px     = i_luma_data_valid && !i_new_frame;
        w_line   = i_new_line && !i_new_frame;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------- rotator
  logic [LOC_W-1:0] w_next_loc;

  gcbp_frame_rotator #(
    .NUM_FRAMES (NUM_FRAMES),
    .LOC_W      (LOC_W)
  ) u_rotator (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rotate     (w_rotate),
    .o_next_loc   (w_next_loc),
    .o_curr_loc   (o_curr_frame_loc),
    .o_prev_loc   (o_prev_frame_loc),
    .o_frame_done (o_frame_done)
  );

  assign o_next_frame_loc = w_next_loc;

  // ---------------------------------------------------------- datapath
  logic [SEL_W-1:0]  r_k;        // clamped plane index
  logic [BANK_W-1:0] r_acc;      // partial word
  logic [FILL_W-1:0] r_fill;     // bits in r_acc
  logic [PIX_W-1:0]  r_pix;      // accepted pixels in this line
  logic [BSEL_W-1:0] r_bank;     // bank of the word being built
  logic [WOFS_W-1:0] r_wofs;     // word offset within the line for r_bank
  logic [LC_W-1:0]   r_line;     // line of the pixels in r_acc
  logic              r_overflow;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [BANK_W-1:0] r_wr_word;
  logic [BANKS-1:0]  r_wr_en;

  logic [SEL_W-1:0]  w_k_clamped;
  logic [LUMA_W:0]   w_luma_ext;
  logic [KX_W-1:0]   w_k0;
  logic [KX_W-1:0]   w_k1;
  logic              w_g;
  logic [BANK_W-1:0] w_acc_base;
  logic [FILL_W-1:0] w_fill_base;
  logic [PIX_W-1:0]  w_pix_base;
  logic [BSEL_W-1:0] w_bank_base;
  logic [WOFS_W-1:0] w_wofs_base;
  logic              w_in_range;
  logic              w_px_ok;
  logic              w_px_drop;
  logic [BANK_W-1:0] w_acc_set;
  logic              w_full;
  logic              w_flush;
  logic [BSEL_W-1:0] w_bank_adv;
  logic [WOFS_W-1:0] w_wofs_adv;
  logic [BANK_W-1:0] w_acc_nxt;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [PIX_W-1:0]  w_pix_nxt;
  logic [BSEL_W-1:0] w_bank_nxt;
  logic [WOFS_W-1:0] w_wofs_nxt;
  logic [ADDR_W-1:0] w_loc_base;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [BANK_W-1:0] w_word_nxt;
  logic [BANKS-1:0]  w_en_nxt;

  // Plane bit: luma[k] ^ luma[k+1], with a zero above the MSB so the top
  // plane is luma[LUMA_W-1] itself.
  always_comb begin
    w_k_clamped = (i_plane_sel >= SEL_W'(LUMA_W - 1)) ? SEL_W'(LUMA_W - 1) : i_plane_sel;
    w_luma_ext  = {1'b0, i_luma_data};
    w_k0        = KX_W'(r_k);
    w_k1        = w_k0 + KX_W'(1);
    w_g         = w_luma_ext[w_k0] ^ w_luma_ext[w_k1];
  end

  // Packing, column stepping and write issue for the current cycle.
  always_comb begin
    // A line start flushes first, so a same-cycle pixel starts from zero.
    w_acc_base  = w_line ? '0 : r_acc;
    w_fill_base = w_line ? '0 : r_fill;
    w_pix_base  = w_line ? '0 : r_pix;
    w_bank_base = w_line ? '0 : r_bank;
    w_wofs_base = w_line ? '0 : r_wofs;

    w_in_range = (w_pix_base < PIX_W'(PIX_PER_LINE)) && (i_line_cnt < LC_W'(LINES));
    w_px_ok    = w_px && w_in_range;
    w_px_drop  = w_px && !w_in_range;
    w_acc_set  = w_acc_base | (BANK_W'(w_g) << w_fill_base);
    w_full     = w_px_ok && (w_fill_base == FILL_W'(BANK_W - 1));
    w_flush    = (w_rotate || w_line) && (r_fill != '0);

    if (w_bank_base == BSEL_W'(BANKS - 1)) begin
      w_bank_adv = '0;
      w_wofs_adv = w_wofs_base + WOFS_W'(1);
    end else begin
      w_bank_adv = w_bank_base + BSEL_W'(1);
      w_wofs_adv = w_wofs_base;
    end

    w_pix_nxt = w_pix_base + PIX_W'(w_px_ok);
    if (w_full) begin
      w_acc_nxt  = '0;
      w_fill_nxt = '0;
      w_bank_nxt = w_bank_adv;
      w_wofs_nxt = w_wofs_adv;
    end else if (w_px_ok) begin
      w_acc_nxt  = w_acc_set;
      w_fill_nxt = w_fill_base + FILL_W'(1);
      w_bank_nxt = w_bank_base;
      w_wofs_nxt = w_wofs_base;
    end else begin
      w_acc_nxt  = w_acc_base;
      w_fill_nxt = w_fill_base;
      w_bank_nxt = w_bank_base;
      w_wofs_nxt = w_wofs_base;
    end

    // Address uses the write buffer as it stands in the completing cycle.
    w_loc_base = ADDR_W'(w_next_loc) * ADDR_W'(FRAME_WORDS);
    w_en_nxt   = '0;
    w_addr_nxt = r_wr_addr;
    w_word_nxt = r_wr_word;
    if (w_flush) begin
      w_en_nxt   = BANKS'(1) << r_bank;
      w_addr_nxt = w_loc_base + ADDR_W'(r_line) * ADDR_W'(WPL) + ADDR_W'(r_wofs);
      w_word_nxt = r_acc;
    end else if (w_full) begin
      w_en_nxt   = BANKS'(1) << w_bank_base;
      w_addr_nxt = w_loc_base + ADDR_W'(i_line_cnt) * ADDR_W'(WPL) + ADDR_W'(w_wofs_base);
      w_word_nxt = w_acc_set;
    end
  end

  // Datapath registers; a frame pulse clears all per-line state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_k        <= '0;
      r_acc      <= '0;
      r_fill     <= '0;
      r_pix      <= '0;
      r_bank     <= '0;
      r_wofs     <= '0;
      r_line     <= '0;
      r_overflow <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_word  <= '0;
      r_wr_en    <= '0;
    end else begin
      r_wr_en    <= w_en_nxt;
      r_wr_addr  <= w_addr_nxt;
      r_wr_word  <= w_word_nxt;
      r_overflow <= r_overflow | w_px_drop;
      if (w_px_ok) r_line <= i_line_cnt;
      if (w_start) begin
        r_k    <= w_k_clamped;
        r_acc  <= '0;
        r_fill <= '0;
        r_pix  <= '0;
        r_bank <= '0;
        r_wofs <= '0;
      end else begin
        r_acc  <= w_acc_nxt;
        r_fill <= w_fill_nxt;
        r_pix  <= w_pix_nxt;
        r_bank <= w_bank_nxt;
        r_wofs <= w_wofs_nxt;
      end
    end
  end

  assign o_bram_array_write_addr   = r_wr_addr;
  assign o_bram_array_write_data   = {BANKS{r_wr_word}};
  assign o_bram_array_write_enable = r_wr_en;
  assign o_overflow                = r_overflow;

`ifdef GCBP_FRAME_STATS_EN
  localparam int ONES_W = clog2(LINES * PIX_PER_LINE + 1);

  logic [ONES_W-1:0] r_ones_cnt;
  logic [ONES_W-1:0] r_plane_ones;

  // Count accepted plane bits equal to 1; publish the total at rotation.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ones_cnt   <= '0;
      r_plane_ones <= '0;
    end else begin
      if (w_rotate) r_plane_ones <= r_ones_cnt;
      if (w_start)                 r_ones_cnt <= '0;
      else if (w_px_ok && w_g)     r_ones_cnt <= r_ones_cnt + ONES_W'(1);
    end
  end

  assign o_plane_ones = r_plane_ones;
`endif

endmodule
